// File: rtl/jt5205_ctrl.sv
// jt5205_ctrl - playback sequencer for the jt5205 ADPCM decoder.
//
// Builds the decoder clock enables from a 384 kHz-equivalent master enable,
// fetches packed ADPCM bytes from ROM and feeds them out one nibble at a
// time, high nibble first.
//
// Ports:
//   rst, clk              asynchronous active-high reset, system clock
//   cen                   master enable (384 kHz equivalent)
//   sel[1:0]              rate: 0 = /96, 1 = /64, 2 = /48, 3 = halted
//   start, stop           one-cycle control pulses (stop has priority)
//   start_addr, end_addr  inclusive byte range to play
//   rom_addr, rom_cs      ROM request; address is stable while rom_cs = 1
//   rom_ok, rom_data      ROM response
//   cen_hf, cen_lo        decoder fast enable and sample enable
//   din[3:0]              nibble presented to the decoder
//   busy                  playback in progress
//   underrun              sticky: a sample strobe found no data
module jt5205_ctrl #(
    parameter int AW = 16
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic [1:0]    sel,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [7:0]    rom_data,
    output logic          cen_hf,
    output logic          cen_lo,
    output logic [3:0]    din,
    output logic          busy,
    output logic          underrun
);

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t        state, state_n;
    logic          busy_n, rom_cs_n, cs_q;
    logic [AW-1:0] ptr, ptr_n, end_q;
    logic [7:0]    cur_b, nxt_b;
    logic          cur_v, cur_v_n, nxt_v, nxt_v_n;
    logic          half, half_n, last_f, last_f_n, underrun_n;
    logic          consume, starve, shift, done, accept;
    logic          cv_s, nv_s, wr_cur, wr_nxt;
    logic [6:0]    div, div_top;

    // Rate divider: the compare against the terminal count (>=) makes a
    // mid-count switch to a shorter period wrap on the very next cen.
    always_comb begin
        case (sel)
            2'd0:    div_top = 7'd95;
            2'd1:    div_top = 7'd63;
            default: div_top = 7'd47;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= 7'd0;
            cen_hf <= 1'b0;
            cen_lo <= 1'b0;
        end else begin
            cen_hf <= cen;
            cen_lo <= 1'b0;
            if (cen && sel != 2'd3) begin
                if (div >= div_top) begin
                    div    <= 7'd0;
                    cen_lo <= 1'b1;
                end else begin
                    div <= div + 7'd1;
                end
            end
        end
    end

    // Playback/fetch control. The nibble engine runs whenever busy; the
    // FSM state only decides whether a ROM request is wanted.
    always_comb begin
        consume = cen_lo && busy && cur_v;
        starve  = cen_lo && busy && !cur_v;
        shift   = consume && half;
        done    = shift && last_f && !nxt_v;
        accept  = rom_cs && cs_q && rom_ok;
        // buffer occupancy after this cycle's consumption
        cv_s    = shift ? nxt_v : cur_v;
        nv_s    = shift ? 1'b0 : nxt_v;

        state_n    = state;
        busy_n     = busy;
        rom_cs_n   = rom_cs;
        ptr_n      = ptr;
        cur_v_n    = cur_v;
        nxt_v_n    = nxt_v;
        half_n     = half;
        last_f_n   = last_f;
        underrun_n = underrun;
        wr_cur     = 1'b0;
        wr_nxt     = 1'b0;

        if (stop) begin
            state_n  = IDLE;
            busy_n   = 1'b0;
            rom_cs_n = 1'b0;
            cur_v_n  = 1'b0;
            nxt_v_n  = 1'b0;
            half_n   = 1'b0;
            last_f_n = 1'b0;
        end else if (start) begin
            // rom_cs is forced low here so any outstanding request is
            // dropped for a cycle before the new address goes out.
            state_n    = FETCH;
            busy_n     = 1'b1;
            rom_cs_n   = 1'b0;
            ptr_n      = start_addr;
            cur_v_n    = 1'b0;
            nxt_v_n    = 1'b0;
            half_n     = 1'b0;
            last_f_n   = 1'b0;
            underrun_n = 1'b0;
        end else begin
            if (consume) half_n = !half;
            if (starve) underrun_n = 1'b1;
            wr_cur  = accept && !cv_s;
            wr_nxt  = accept && cv_s;
            cur_v_n = cv_s || wr_cur;
            nxt_v_n = nv_s || wr_nxt;
            case (state)
                FETCH: begin
                    if (accept) begin
                        rom_cs_n = 1'b0;
                        if (ptr == end_q) begin
                            last_f_n = 1'b1;
                            state_n  = PLAY;
                        end else begin
                            ptr_n = ptr + AW'(1);
                            if (cur_v_n && nxt_v_n) state_n = PLAY;
                        end
                    end else if (!rom_cs) begin
                        rom_cs_n = 1'b1;
                    end
                end
                PLAY: begin
                    if (done) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        half_n  = 1'b0;
                        cur_v_n = 1'b0;
                    end else if (shift && !last_f) begin
                        state_n = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rom_cs   <= 1'b0;
            cs_q     <= 1'b0;
            ptr      <= '0;
            cur_v    <= 1'b0;
            nxt_v    <= 1'b0;
            half     <= 1'b0;
            last_f   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= busy_n;
            rom_cs   <= rom_cs_n;
            cs_q     <= rom_cs;
            ptr      <= ptr_n;
            cur_v    <= cur_v_n;
            nxt_v    <= nxt_v_n;
            half     <= half_n;
            last_f   <= last_f_n;
            underrun <= underrun_n;
        end
    end

    // Byte buffers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (start && !stop) end_q <= end_addr;
        if (wr_cur)     cur_b <= rom_data;
        else if (shift) cur_b <= nxt_b;
        if (wr_nxt)     nxt_b <= rom_data;
    end

    assign rom_addr = ptr;
    assign din      = (busy && cur_v) ? (half ? cur_b[3:0] : cur_b[7:4]) : 4'd0;

endmodule

// File: tb/tb_jt5205_ctrl.sv
module tb_jt5205_ctrl;
    localparam int AW = 16;

    logic          rst, clk, cen, start, stop, rom_cs, rom_ok;
    logic          cen_hf, cen_lo, busy, underrun;
    logic [1:0]    sel;
    logic [AW-1:0] start_addr, end_addr, rom_addr;
    logic [7:0]    rom_data;
    logic [3:0]    din;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int cen_per = 0;
    int rom_lat = 2;
    bit force_ok = 0;
    bit mon_en = 0;
    int nib_seen = 0;
    int last_lo_cyc = 0;
    logic [3:0]  exp_q[$];
    logic [15:0] exp_addr[$];
    logic [15:0] got_addr[$];

    typedef struct {
        logic [15:0] sa;
        logic [15:0] ea;
        int          len;
    } vec_t;
    vec_t vecs[5];

    jt5205_ctrl #(.AW(AW)) dut (
        .rst(rst), .clk(clk), .cen(cen), .sel(sel), .start(start), .stop(stop),
        .start_addr(start_addr), .end_addr(end_addr), .rom_addr(rom_addr),
        .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data), .cen_hf(cen_hf),
        .cen_lo(cen_lo), .din(din), .busy(busy), .underrun(underrun)
    );

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        logic [15:0] t;
        if (a == 16'h0100) return 8'hA5;
        if (a == 16'h0101) return 8'h3C;
        t = a * 16'd37 + 16'd11;
        return t[7:0] ^ a[15:8];
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // master enable generator
    initial begin
        int cnt;
        cnt = 0;
        cen = 0;
        forever begin
            @(posedge clk); #1;
            cnt++;
            cen = (cen_per != 0) && ((cnt % cen_per) == 0);
        end
    end

    // ROM model: rom_ok after rom_lat cycles of continuous rom_cs
    initial begin
        int age;
        age = 0;
        rom_ok = 0;
        rom_data = 0;
        forever begin
            @(posedge clk); #1;
            if (rom_cs) age++; else age = 0;
            rom_ok = force_ok || (rom_cs && age >= rom_lat);
            rom_data = rom_fn(rom_addr);
        end
    end

    // fetch-address recorder and nibble scoreboard
    initial begin
        bit csp;
        csp = 0;
        forever begin
            @(negedge clk);
            if (rom_cs && rom_ok && csp) got_addr.push_back(rom_addr);
            csp = rom_cs;
            if (mon_en && cen_lo && busy) begin
                nib_seen++;
                last_lo_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_nibble: got din=%0h expected no strobe", din);
                end else begin
                    check("nibble", din, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    task automatic wait_lo(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (cen_lo) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse(input logic [15:0] sa, input logic [15:0] ea, input bit st, input bit sp);
        @(posedge clk); #1;
        start_addr = sa;
        end_addr = ea;
        start = st;
        stop = sp;
        @(posedge clk); #1;
        start = 0;
        stop = 0;
    endtask

    task automatic play(input logic [15:0] sa, input logic [15:0] ea, input int len);
        bit ok;
        logic [15:0] a;
        logic [7:0] b;
        int fall;
        exp_q.delete();
        exp_addr.delete();
        got_addr.delete();
        nib_seen = 0;
        wait_lo(400, ok);
        check("sync_lo", ok, 1);
        a = sa;
        for (int i = 0; i < len; i++) begin
            b = rom_fn(a);
            exp_addr.push_back(a);
            exp_q.push_back(b[7:4]);
            exp_q.push_back(b[3:0]);
            a = a + 16'd1;
        end
        mon_en = 1;
        pulse(sa, ea, 1, 0);
        @(negedge clk);
        check("busy_set", busy, 1);
        check("underrun_clear", underrun, 0);
        ok = 0;
        for (int i = 0; i < len * 2 * 200 + 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        fall = cyc;
        mon_en = 0;
        check("busy_fall", ok, 1);
        check("nibble_count", nib_seen, 2 * len);
        check("queue_left", exp_q.size(), 0);
        check("busy_fall_delay", fall - last_lo_cyc, 1);
        check("addr_count", got_addr.size(), len);
        for (int i = 0; i < len && i < got_addr.size(); i++)
            check("fetch_addr", got_addr[i], exp_addr[i]);
        check("din_idle", din, 0);
        check("rom_cs_idle", rom_cs, 0);
    endtask

    initial begin
        bit ok;
        int t0, n;
        logic [7:0] b;

        vecs[0] = '{16'h0100, 16'h0101, 2};
        vecs[1] = '{16'hFFFF, 16'h0000, 2};
        vecs[2] = '{16'h0200, 16'h0200, 1};
        vecs[3] = '{16'hFFFE, 16'h0001, 4};
        vecs[4] = '{16'h0010, 16'h0014, 5};

        rst = 1; sel = 2; start = 0; stop = 0; start_addr = 0; end_addr = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rom_cs", rom_cs, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_din", din, 0);
        check("rst_cen_hf", cen_hf, 0);
        check("rst_cen_lo", cen_lo, 0);
        check("rst_underrun", underrun, 0);
        @(posedge clk); #1;
        rst = 0;

        // strobes at sel = 2, cen every 4 clk
        cen_per = 4;
        wait_lo(400, ok);
        check("lo_first", ok, 1);
        for (int k = 0; k < 2; k++) begin
            t0 = cyc;
            wait_lo(400, ok);
            check("lo_seen", ok, 1);
            check("lo_period", cyc - t0, 192);
            check("lo_with_hf", cen_hf, 1);
        end
        sel = 3;
        n = 0;
        t0 = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cen_lo) n++;
            if (cen_hf) t0++;
        end
        check("halted_lo", n, 0);
        check("halted_hf", t0, 100);
        sel = 2;

        for (int v = 0; v < 5; v++) play(vecs[v].sa, vecs[v].ea, vecs[v].len);

        // late ROM data with cen every clk
        cen_per = 1;
        rom_lat = 300;
        wait_lo(100, ok);
        pulse(16'h0300, 16'h0300, 1, 0);
        wait_lo(100, ok);
        check("starved_din", din, 0);
        check("starved_busy", busy, 1);
        @(negedge clk);
        check("underrun_set", underrun, 1);
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rom_cs && rom_ok) begin
                ok = 1;
                break;
            end
        end
        check("late_data", ok, 1);
        b = rom_fn(16'h0300);
        wait_lo(100, ok);
        check("resume_hi", din, b[7:4]);
        wait_lo(100, ok);
        check("resume_lo", din, b[3:0]);
        @(negedge clk);
        check("late_busy_done", busy, 0);
        check("underrun_sticky", underrun, 1);

        // stop while a request is outstanding
        cen_per = 4;
        rom_lat = 20;
        pulse(16'h0400, 16'h0405, 1, 0);
        @(negedge clk);
        check("start_clears_underrun", underrun, 0);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rom_cs) begin
                ok = 1;
                break;
            end
        end
        check("cs_before_stop", ok, 1);
        pulse(16'h0400, 16'h0405, 0, 1);
        @(negedge clk);
        check("stop_rom_cs", rom_cs, 0);
        check("stop_busy", busy, 0);
        check("stop_din", din, 0);
        force_ok = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("late_ok_din", din, 0);
            check("late_ok_busy", busy, 0);
        end
        force_ok = 0;

        // start and stop together, then restart while busy
        pulse(16'h0500, 16'h0510, 1, 0);
        repeat (3) @(negedge clk);
        pulse(16'h0700, 16'h0710, 1, 1);
        @(negedge clk);
        check("both_busy", busy, 0);
        check("both_rom_cs", rom_cs, 0);
        pulse(16'h0500, 16'h0510, 1, 0);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rom_cs) begin
                ok = 1;
                break;
            end
        end
        check("cs_before_restart", ok, 1);
        pulse(16'h0600, 16'h0610, 1, 0);
        @(negedge clk);
        check("restart_gap", rom_cs, 0);
        check("restart_busy", busy, 1);
        @(negedge clk);
        check("restart_cs", rom_cs, 1);
        check("restart_addr", rom_addr, 16'h0600);

        // asynchronous reset mid-playback
        rst = 1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rom_cs", rom_cs, 0);
        check("arst_rom_addr", rom_addr, 0);
        check("arst_din", din, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
